dmem_hs: RTL
============

// Module: dmem_hs
// PURPOSE
//  Parametrised data memory with valid/ready request and response channels, byte enables and
//  programmable response latency. Serves the CPU load/store unit; replaces the fixed 16-bit
//  always-ready data memory. One transaction in flight; every request gets one response.
// PARAMETERS
//  DATA_W  16   data width in bits; multiple of 8
//  ADDR_W  16   byte-address width
//  DEPTH   256  number of DATA_W words; power of 2
//  RD_LAT  1    cycles from request accept to rsp_valid; legal range 1..4
// PORTS
//  clk        in   1         clock, rising edge
//  rst_n      in   1         asynchronous active-low reset
//  req_valid  in   1         request present
//  req_ready  out  1         request accepted when req_valid && req_ready
//  req_we     in   1         1 = write, 0 = read
//  req_addr   in   ADDR_W    byte address
//  req_wdata  in   DATA_W    write data
//  req_be     in   DATA_W/8  byte enables; bit i controls req_wdata[8i+7:8i]
//  rsp_valid  out  1         response present
//  rsp_ready  in   1         response consumed when rsp_valid && rsp_ready
//  rsp_rdata  out  DATA_W    read data; 0 for write responses
//  rsp_err    out  1         error flag; meaningful only while rsp_valid
// BEHAVIOUR
//  - Reset: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, counter=0.
//    Memory contents are not reset.
//  - Word index = req_addr >> log2(DATA_W/8); the low address bits select a byte lane.
//  - FSM states:
//    - IDLE: req_ready=1. On accept, latch we, err and read data.
//      - RD_LAT==1: go to RESP.
//      - otherwise: go to WAIT with cnt = RD_LAT-1.
//    - WAIT: req_ready=0. Decrement cnt each cycle; at cnt==1, go to RESP.
//    - RESP: rsp_valid=1, outputs held stable. On rsp_ready, go to IDLE.
//  - Timing:
//    - Accept at edge N gives rsp_valid high from edge N+RD_LAT.
//    - Back-to-back throughput with rsp_ready=1: one transaction per RD_LAT+1 cycles.
//  - Write: commits at the accept edge. Only bytes with req_be[i]=1 change; req_be=0 is a
//    legal no-op that still gets a response.
//  - Read: array is read at the accept edge and the value is held internally until RESP.
//    Read-after-write with the next request returns the new data.
//  - req_valid while req_ready=0 is ignored; the requester must hold the request until accepted.
//  - rsp_rdata and rsp_err change only on entry to RESP.
//  - Reset mid-operation: the pending response is dropped and the FSM returns to IDLE. A write
//    already accepted remains in the array.
// CONFIGURATION
//  DMEM_ERR_EN defined:
//    - rsp_err=1 when the word index >= DEPTH, or when the access is misaligned
//      (req_addr low bits != 0 while req_be is all ones).
//    - On error: no array write, rsp_rdata=0. The response is still delivered with normal latency.
//  DMEM_ERR_EN undefined:
//    - Word index is taken modulo DEPTH (upper bits ignored) and low address bits are ignored
//      for full-word access.
//    - rsp_err is tied 0.
// TESTING
//  1. Reset: rst_n=0 mid-WAIT (RD_LAT=3) -> rsp_valid=0, req_ready=1 asynchronously.
//     After release, a read of the previously accepted write address returns its data.
//  2. Write 0xBEEF @0x0004, then read @0x0004 (RD_LAT=1, rsp_ready=1):
//     - rsp_valid one cycle after each accept, rdata=0xBEEF.
//     - req_ready low for exactly 1 cycle per transaction.
//  3. Byte enable: write 0x1234 @0x10, then write 0xAB00 be=2'b10, then read @0x10
//     -> rdata=0xAB34.
//  4. Backpressure: RD_LAT=2, rsp_ready=0 for 5 cycles -> rsp_valid, rdata and err stay stable;
//     req_ready=0 throughout; a second req_valid is not accepted until the response is consumed.
//  5. Latency sweep RD_LAT=1..4: count cycles from the accept edge to the first rsp_valid
//     -> equals RD_LAT.
//  6. DMEM_ERR_EN, DEPTH=256:
//     - Write @0x0200 -> rsp_err=1 and array unchanged.
//     - Without the macro, the same write aliases to @0x0000 and rsp_err=0.

Source files
------------

// File: rtl/dmem_hs.sv
// dmem_hs: valid/ready data memory with byte enables and an RD_LAT-cycle response latency.
// Define DMEM_ERR_EN to flag out-of-range and misaligned full-word accesses instead of aliasing them.
module dmem_hs #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 256,
    parameter int RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            state;
    logic [1:0]        cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] hold_rdata;
    logic [DATA_W-1:0] rdata_nx;
    logic              hold_err;
    logic              err;
    logic              acc;
    logic [IDX_W-1:0]  idx;
    assign acc = req_valid && req_ready;
    assign idx = IDX_W'(req_addr >> OFF_W);
`ifdef DMEM_ERR_EN
    assign err = (((req_addr >> OFF_W) >> IDX_W) != '0) ||
                 (((req_addr & ADDR_W'(NB - 1)) != '0) && (&req_be));
`else
    assign err = 1'b0;
`endif
    assign rdata_nx = (req_we || err) ? '0 : mem[idx];
    always_ff @(posedge clk)
        if (acc && req_we && !err)
            for (int i = 0; i < NB; i++)
                if (req_be[i]) mem[idx][8*i +: 8] <= req_wdata[8*i +: 8];
    // Response data is captured at accept and only presented on entry to RESP.
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 2'd0;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
            hold_rdata <= '0;
            hold_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_valid) begin
                    hold_rdata <= rdata_nx;
                    hold_err   <= err;
                    req_ready  <= 1'b0;
                    if (RD_LAT == 1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rdata_nx;
                        rsp_err   <= err;
                    end else begin
                        state <= WAIT;
                        cnt   <= 2'(RD_LAT - 1);
                    end
                end
                WAIT: begin
                    cnt <= cnt - 2'd1;
                    if (cnt == 2'd1) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= hold_rdata;
                        rsp_err   <= hold_err;
                    end
                end
                RESP: if (rsp_ready) begin
                    state     <= IDLE;
                    rsp_valid <= 1'b0;
                    req_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
endmodule
